// File: rtl/nonrestoring_divider.sv
// nonrestoring_divider: iterative unsigned divider, one WIDTH+1-bit add/sub
// step per clock. The sign of the partial remainder selects add or subtract
// for the next step, and a final FIX cycle restores a negative remainder.
//
// Optional feature: define DIVIDER_SIGNED_EN for two's-complement operands.
// Magnitudes go through the same core, and the result signs are applied in
// FIX (truncating division).
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start            request, sampled only in IDLE
//   dividend/divisor operands, captured on the accepted start edge
//   busy             high from the accepted start until done
//   done             one-cycle pulse; results are valid from this cycle
//   quotient         result, held until the next accepted start
//   remainder        result, held until the next accepted start
//   div_by_zero      flag for the last operation, held with the results
module nonrestoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned PW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    p, p_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [WIDTH-1:0] d, d_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             busy_nxt, done_nxt, dbz_nxt;
  logic [WIDTH-1:0] quotient_nxt, remainder_nxt;

  logic [PW-1:0]    d_ext, p_shift, p_step, p_fix;
  logic [WIDTH-1:0] a_mag, b_mag, q_res, r_res;

`ifdef DIVIDER_SIGNED_EN
  logic neg_q, neg_q_nxt;
  logic neg_r, neg_r_nxt;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      p           <= p_nxt;
      q           <= q_nxt;
      d           <= d_nxt;
      cnt         <= cnt_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
      div_by_zero <= dbz_nxt;
`ifdef DIVIDER_SIGNED_EN
      neg_q       <= neg_q_nxt;
      neg_r       <= neg_r_nxt;
`endif
    end
  end

  // Next-state, datapath step and result formatting
  always_comb begin
    state_nxt     = state;
    p_nxt         = p;
    q_nxt         = q;
    d_nxt         = d;
    cnt_nxt       = cnt;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    quotient_nxt  = quotient;
    remainder_nxt = remainder;
    dbz_nxt       = div_by_zero;
`ifdef DIVIDER_SIGNED_EN
    neg_q_nxt     = neg_q;
    neg_r_nxt     = neg_r;
`endif

    // One non-restoring step; wraparound in the shift is harmless because
    // the result after +/-D always lands back in [-D, D).
    d_ext   = {1'b0, d};
    p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
    p_step  = p[WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);
    p_fix   = p[WIDTH] ? (p + d_ext) : p;
    q_res   = q;
    r_res   = p_fix[WIDTH-1:0];

`ifdef DIVIDER_SIGNED_EN
    a_mag = dividend[WIDTH-1] ? WIDTH'(-dividend) : dividend;
    b_mag = divisor[WIDTH-1]  ? WIDTH'(-divisor)  : divisor;
    if (neg_q) q_res = WIDTH'(-q);
    if (neg_r) r_res = WIDTH'(-p_fix[WIDTH-1:0]);
`else
    a_mag = dividend;
    b_mag = divisor;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          busy_nxt = 1'b1;
          dbz_nxt  = 1'b0;
          if (divisor == '0) begin
            // No iteration needed; DONE raises the pulse one edge later.
            quotient_nxt  = '1;
            remainder_nxt = dividend;
            dbz_nxt       = 1'b1;
            state_nxt     = DONE;
          end else begin
            p_nxt     = '0;
            q_nxt     = a_mag;
            d_nxt     = b_mag;
            cnt_nxt   = '0;
`ifdef DIVIDER_SIGNED_EN
            neg_q_nxt = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_nxt = dividend[WIDTH-1];
`endif
            state_nxt = RUN;
          end
        end
      end

      RUN: begin
        p_nxt   = p_step;
        q_nxt   = {q[WIDTH-2:0], ~p_step[WIDTH]};
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      end

      FIX: begin
        p_nxt         = p_fix;
        quotient_nxt  = q_res;
        remainder_nxt = r_res;
        done_nxt      = 1'b1;
        busy_nxt      = 1'b0;
        state_nxt     = DONE;
      end

      DONE: begin
        // Still busy only on the divide-by-zero path: raise done here and
        // spend one more cycle in DONE so the pulse cycle also ignores start.
        if (busy) begin
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
